// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants for the round-robin mux arbiter.
// Mode encodings used by the top level and by testbenches.
package rr_mux_arbiter_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational picker: first set request at or after Start, wrapping around.
// The search runs over {Req, Req} so the wrap needs no special case.
module rr_pick #(
   parameter int unsigned N    = 4,
   parameter int unsigned SELW = $clog2(N)
) (
   input  logic [N-1:0]    Req,
   input  logic [SELW-1:0] Start,
   output logic [N-1:0]    Grant,
   output logic [SELW-1:0] Idx
);

   localparam int unsigned DW = SELW + 1;

   logic [2*N-1:0] dbl;
   logic [DW-1:0]  pos;
   logic           found;

   assign dbl = {Req, Req};

   always_comb begin
      Grant = '0;
      Idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int j = 0; j < N; j++) begin
         pos = DW'(Start) + DW'(j);
         if (!found && dbl[pos]) begin
            found = 1'b1;
            Idx   = (pos >= DW'(N)) ? SELW'(pos - DW'(N)) : SELW'(pos);
         end
      end
      if (found) Grant[Idx] = 1'b1;
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-input arbitrated selector with valid/ready handshakes and a registered output.
// Fixed-priority or round-robin arbitration; losers are back-pressured.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned N     = 4,
   parameter int unsigned SELW  = $clog2(N)
) (
   input  logic               Clk,
   input  logic               ResetN,
   input  logic               Mode,
   input  logic [N*WIDTH-1:0] InData,
   input  logic [N-1:0]       InValid,
   output logic [N-1:0]       InReady,
   output logic [WIDTH-1:0]   OutData,
   output logic [SELW-1:0]    OutSel,
   output logic               OutValid,
   input  logic               OutReady
);

   logic [SELW-1:0]  last;
   logic [SELW-1:0]  rr_start;
   logic [SELW-1:0]  start;
   logic [SELW-1:0]  win_idx;
   logic [N-1:0]     grant;
   logic [WIDTH-1:0] win_data;
   logic             free;
   logic             any_valid;

   assign free      = !OutValid || OutReady;
   assign any_valid = |InValid;

   // Round-robin search begins just after the last channel served.
   assign rr_start = (last == SELW'(N - 1)) ? '0 : last + SELW'(1);
   assign start    = (Mode == MODE_RR) ? rr_start : '0;

   rr_pick #(
      .N    (N),
      .SELW (SELW)
   ) u_pick (
      .Req   (InValid),
      .Start (start),
      .Grant (grant),
      .Idx   (win_idx)
   );

   // Grant only into a free slot; nothing is accepted while held in reset.
   assign InReady = (free && ResetN) ? grant : '0;

   always_comb begin
      win_data = '0;
      for (int i = 0; i < N; i++) begin
         if (win_idx == SELW'(i)) win_data = InData[i*WIDTH +: WIDTH];
      end
   end

   // Output register and last-served pointer.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         OutValid <= 1'b0;
         OutData  <= '0;
         OutSel   <= '0;
         last     <= SELW'(N - 1);
      end else if (free) begin
         if (any_valid) begin
            OutValid <= 1'b1;
            OutData  <= win_data;
            OutSel   <= win_idx;
            last     <= win_idx;
         end else begin
            OutValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with N=4, WIDTH=5.
module tb_rr_mux_arbiter;

   logic        Clk;
   logic        ResetN;
   logic        Mode;
   logic [19:0] InData;
   logic [3:0]  InValid;
   logic [3:0]  InReady;
   logic [4:0]  OutData;
   logic [1:0]  OutSel;
   logic        OutValid;
   logic        OutReady;

   int total = 0;
   int bad   = 0;

   rr_mux_arbiter #(.WIDTH(5), .N(4)) dut (
      .Clk      (Clk),
      .ResetN   (ResetN),
      .Mode     (Mode),
      .InData   (InData),
      .InValid  (InValid),
      .InReady  (InReady),
      .OutData  (OutData),
      .OutSel   (OutSel),
      .OutValid (OutValid),
      .OutReady (OutReady)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   // Expected output word after one edge.
   task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [4:0] d);
      chk({tag, ".valid"}, 32'(OutValid), 32'(v));
      chk({tag, ".sel"},   32'(OutSel),   32'(s));
      chk({tag, ".data"},  32'(OutData),  32'(d));
   endtask

   logic [1:0] rr_seq [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [1:0] sk_seq [5]  = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
   logic [4:0] dat    [4]  = '{5'h10, 5'h11, 5'h15, 5'h13};

   initial begin
      ResetN   = 1'b0;
      Mode     = 1'b0;
      InValid  = 4'b0000;
      OutReady = 1'b0;
      InData   = {5'h13, 5'h15, 5'h11, 5'h10};
      step();
      step();
      chk_out("reset", 1'b0, 2'd0, 5'h00);
      chk("reset.inready", 32'(InReady), 32'h0);
      ResetN = 1'b1;

      // Fixed priority: channel 1 always beats channel 3.
      Mode = 1'b0; InValid = 4'b1010; OutReady = 1'b1;
      #1 chk("fixed.inready0", 32'(InReady), 32'b0010);
      for (int k = 0; k < 3; k++) begin
         step();
         chk_out("fixed", 1'b1, 2'd1, 5'h11);
         chk("fixed.inready", 32'(InReady), 32'b0010);
      end

      // Round-robin skip: last=1, so 3 then alternate with 0, ending on 3.
      Mode = 1'b1; InValid = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_out("rrskip", 1'b1, sk_seq[k], dat[sk_seq[k]]);
      end

      // Round-robin fairness from last=3.
      InValid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_out("rrfair", 1'b1, rr_seq[k], dat[rr_seq[k]]);
      end

      // Back-pressure on a channel-2 word.
      Mode = 1'b0; InValid = 4'b0100;
      step();
      chk_out("bp.load", 1'b1, 2'd2, 5'h15);
      OutReady = 1'b0; InValid = 4'b1111;
      #1 chk("bp.inready0", 32'(InReady), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk_out("bp.hold", 1'b1, 2'd2, 5'h15);
         chk("bp.inready", 32'(InReady), 32'h0);
      end
      OutReady = 1'b1;
      #1 chk("bp.release.inready", 32'(InReady), 32'b0001);
      step();
      chk_out("bp.release", 1'b1, 2'd0, 5'h10);

      // Empty drain: one channel-3 word, then nothing valid.
      InValid = 4'b1000;
      step();
      chk_out("drain.load", 1'b1, 2'd3, 5'h13);
      InValid = 4'b0000;
      step();
      chk_out("drain.empty", 1'b0, 2'd3, 5'h13);
      chk("drain.inready", 32'(InReady), 32'h0);

      // Async reset mid-stream during round-robin traffic (last=3).
      Mode = 1'b1; InValid = 4'b1111;
      step();
      chk_out("ars.pre0", 1'b1, 2'd0, 5'h10);
      step();
      chk_out("ars.pre1", 1'b1, 2'd1, 5'h11);
      #2 ResetN = 1'b0;
      #1 chk_out("ars.inreset", 1'b0, 2'd0, 5'h00);
      chk("ars.inready", 32'(InReady), 32'h0);
      step();
      ResetN = 1'b1;
      #1 chk("ars.post.inready", 32'(InReady), 32'b0001);
      step();
      chk_out("ars.post", 1'b1, 2'd0, 5'h10);
      step();
      chk_out("ars.post2", 1'b1, 2'd1, 5'h11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
